// File: rtl/noise_lfsr.sv
// Noise-channel shift register: holds the noise control register, detects rising edges of
// noise_clk and advances a periodic or white-noise LFSR, reloading it on every register write.
module noise_lfsr #(
  parameter int unsigned      WIDTH = 15,
  parameter int unsigned      TAP_A = 0,
  parameter int unsigned      TAP_B = 1,
  parameter logic [WIDTH-1:0] SEED  = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       noise_wr,
  input  logic [2:0] noise_data,
  input  logic       noise_clk,
  output logic [1:0] rate_sel,
  output logic       noise_out,
  output logic       shift_stb
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] TapAIdx = IdxW'(TAP_A);
  localparam logic [IdxW-1:0] TapBIdx = IdxW'(TAP_B);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             fb_q, fb_d;
  logic [1:0]       rate_q, rate_d;
  logic             nclk_q, nclk_d;
  logic             stb_q, stb_d;
  logic             shift_req;
  logic             feed;

  always_comb begin
    shift_req = noise_clk & ~nclk_q;
    feed      = fb_q ? (lfsr_q[TapAIdx] ^ lfsr_q[TapBIdx]) : lfsr_q[0];
    lfsr_d    = lfsr_q;
    fb_d      = fb_q;
    rate_d    = rate_q;
    nclk_d    = noise_clk;
    stb_d     = 1'b0;
    // A write reloads the LFSR and swallows a coincident edge; nclk_q still tracks the level.
    if (noise_wr) begin
      lfsr_d = SEED;
      fb_d   = noise_data[2];
      rate_d = noise_data[1:0];
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else if (shift_req) begin
      lfsr_d = {feed, lfsr_q[WIDTH-1:1]};
      stb_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      fb_q   <= 1'b0;
      rate_q <= 2'b00;
      nclk_q <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      fb_q   <= fb_d;
      rate_q <= rate_d;
      nclk_q <= nclk_d;
      stb_q  <= stb_d;
    end
  end

  assign rate_sel  = rate_q;
  assign noise_out = lfsr_q[0];
  assign shift_stb = stb_q;

endmodule
